// File: rtl/bep_frame_controller.sv
// -----------------------------------------------------------------------------
// bep_frame_controller
//
// Sequences a serial frame shift-register decoder. The raw serial clock and data
// are synchronised into the system clock domain. Each serial-clock rising edge
// becomes a single-cycle shift strobe to the decoder. The decoder is cleared
// between frames, and the gap between serial edges is policed once a frame has
// started. On completion the controller checks the bit count and the preamble,
// then holds a good frame until a valid/ack consumer takes it.
//
// Ports
//   clock, reset      system clock, synchronous active-high reset
//   serial_clk_in     raw asynchronous serial clock
//   serial_dat_in     raw asynchronous serial data
//   dec_reset         decoder clear strobe (one cycle, during CLEAR)
//   dec_shift         one-cycle decoder shift strobe
//   dec_data          bit to shift, meaningful while dec_shift=1
//   dec_full          decoder full flag
//   dec_preamble      decoder preamble field
//   frame_valid       decoder holds a checked good frame
//   frame_ack         consumer has taken the frame (honoured only in HOLD)
//   frame_error       one-cycle pulse when a frame is rejected
//   error_code        01 gap timeout, 10 bad preamble, 11 length mismatch
//   busy              at least one bit of the current frame received
//   frames_ok         saturating good-frame count
//   frames_bad        saturating rejected-frame count
// -----------------------------------------------------------------------------
module bep_frame_controller #(
    parameter int unsigned FRAME_BITS  = 192,
    parameter logic [31:0] PREAMBLE    = 32'hAAAAAAAA,
    parameter logic [19:0] GAP_TIMEOUT = 20'd500000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        serial_clk_in,
    input  logic        serial_dat_in,
    output logic        dec_reset,
    output logic        dec_shift,
    output logic        dec_data,
    input  logic        dec_full,
    input  logic [31:0] dec_preamble,
    output logic        frame_valid,
    input  logic        frame_ack,
    output logic        frame_error,
    output logic [1:0]  error_code,
    output logic        busy,
    output logic [7:0]  frames_ok,
    output logic [7:0]  frames_bad
);

    typedef enum logic [1:0] {
        ST_CLEAR   = 2'd0,
        ST_RECEIVE = 2'd1,
        ST_CHECK   = 2'd2,
        ST_HOLD    = 2'd3
    } state_t;

    localparam logic [7:0] FRAME_BITS_C = 8'(FRAME_BITS);
    localparam logic [1:0] ERR_GAP      = 2'b01;
    localparam logic [1:0] ERR_PREAMBLE = 2'b10;
    localparam logic [1:0] ERR_LENGTH   = 2'b11;

    // Saturating 8-bit increment used by the frame counters.
    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        logic [7:0] result;
        if (value == 8'hFF) begin
            result = value;
        end else begin
            result = value + 8'd1;
        end
        return result;
    endfunction

    logic        clk_sync1_r, clk_sync2_r, clk_sync3_r;
    logic        dat_sync1_r, dat_sync2_r;
    logic        edge_s;

    state_t      state_r, state_next_s;
    logic [7:0]  bit_cnt_r, bit_cnt_next_s;
    logic [19:0] gap_cnt_r, gap_cnt_next_s;
    logic [19:0] gap_inc_s;

    logic        dec_reset_r, dec_reset_next_s;
    logic        dec_shift_r, dec_shift_next_s;
    logic        dec_data_r, dec_data_next_s;
    logic        frame_valid_r, frame_valid_next_s;
    logic        frame_error_r, frame_error_next_s;
    logic [1:0]  error_code_r, error_code_next_s;
    logic        busy_r, busy_next_s;
    logic [7:0]  frames_ok_r, frames_ok_next_s;
    logic [7:0]  frames_bad_r, frames_bad_next_s;

    // Two-flop synchronisers for serial clock and data, plus an edge-detect stage on the clock.
    always_ff @(posedge clock) begin
        if (reset) begin
            clk_sync1_r <= 1'b0;
            clk_sync2_r <= 1'b0;
            clk_sync3_r <= 1'b0;
            dat_sync1_r <= 1'b0;
            dat_sync2_r <= 1'b0;
        end else begin
            clk_sync1_r <= serial_clk_in;
            clk_sync2_r <= clk_sync1_r;
            clk_sync3_r <= clk_sync2_r;
            dat_sync1_r <= serial_dat_in;
            dat_sync2_r <= dat_sync1_r;
        end
    end

    assign edge_s    = clk_sync2_r & ~clk_sync3_r;
    assign gap_inc_s = gap_cnt_r + 20'd1;

    // Next-state, counter and output decode for the frame sequencer.
    always_comb begin
        state_next_s       = state_r;
        bit_cnt_next_s     = bit_cnt_r;
        gap_cnt_next_s     = gap_cnt_r;
        dec_reset_next_s   = 1'b0;
        dec_shift_next_s   = 1'b0;
        dec_data_next_s    = 1'b0;
        frame_valid_next_s = 1'b0;
        frame_error_next_s = 1'b0;
        error_code_next_s  = error_code_r;
        busy_next_s        = 1'b0;
        frames_ok_next_s   = frames_ok_r;
        frames_bad_next_s  = frames_bad_r;

        case (state_r)
            ST_CLEAR: begin
                bit_cnt_next_s = 8'd0;
                gap_cnt_next_s = 20'd0;
                // Straight after reset dec_reset_r is still low, so CLEAR stays
                // one extra cycle to make sure the decoder clear pulse is issued.
                if (dec_reset_r) begin
                    state_next_s = ST_RECEIVE;
                end else begin
                    state_next_s = ST_CLEAR;
                end
            end

            ST_RECEIVE: begin
                if (dec_full) begin
                    state_next_s = ST_CHECK;
                end else if (edge_s) begin
                    dec_shift_next_s = 1'b1;
                    dec_data_next_s  = dat_sync2_r;
                    bit_cnt_next_s   = sat_inc8(bit_cnt_r);
                    gap_cnt_next_s   = 20'd0;
                end else if (bit_cnt_r != 8'd0) begin
                    // Firing as the count reaches the limit makes the error
                    // pulse land exactly GAP_TIMEOUT cycles after the last shift.
                    if (gap_inc_s == GAP_TIMEOUT) begin
                        frame_error_next_s = 1'b1;
                        error_code_next_s  = ERR_GAP;
                        frames_bad_next_s  = sat_inc8(frames_bad_r);
                        state_next_s       = ST_CLEAR;
                    end else begin
                        gap_cnt_next_s = gap_inc_s;
                    end
                end else begin
                    gap_cnt_next_s = 20'd0;
                end
            end

            ST_CHECK: begin
                if (bit_cnt_r != FRAME_BITS_C) begin
                    frame_error_next_s = 1'b1;
                    error_code_next_s  = ERR_LENGTH;
                    frames_bad_next_s  = sat_inc8(frames_bad_r);
                    state_next_s       = ST_CLEAR;
                end else if (dec_preamble != PREAMBLE) begin
                    frame_error_next_s = 1'b1;
                    error_code_next_s  = ERR_PREAMBLE;
                    frames_bad_next_s  = sat_inc8(frames_bad_r);
                    state_next_s       = ST_CLEAR;
                end else begin
                    frames_ok_next_s = sat_inc8(frames_ok_r);
                    state_next_s     = ST_HOLD;
                end
            end

            ST_HOLD: begin
                if (frame_ack) begin
                    state_next_s = ST_CLEAR;
                end else begin
                    state_next_s = ST_HOLD;
                end
            end

            default: begin
                state_next_s = ST_CLEAR;
            end
        endcase

        // Status outputs are registered, so they are decoded from the state being entered.
        dec_reset_next_s   = (state_next_s == ST_CLEAR);
        frame_valid_next_s = (state_next_s == ST_HOLD);
        busy_next_s        = ((state_next_s == ST_RECEIVE) && (bit_cnt_next_s != 8'd0)) ||
                             (state_next_s == ST_CHECK);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r       <= ST_CLEAR;
            bit_cnt_r     <= 8'd0;
            gap_cnt_r     <= 20'd0;
            dec_reset_r   <= 1'b0;
            dec_shift_r   <= 1'b0;
            dec_data_r    <= 1'b0;
            frame_valid_r <= 1'b0;
            frame_error_r <= 1'b0;
            error_code_r  <= 2'b00;
            busy_r        <= 1'b0;
            frames_ok_r   <= 8'd0;
            frames_bad_r  <= 8'd0;
        end else begin
            state_r       <= state_next_s;
            bit_cnt_r     <= bit_cnt_next_s;
            gap_cnt_r     <= gap_cnt_next_s;
            dec_reset_r   <= dec_reset_next_s;
            dec_shift_r   <= dec_shift_next_s;
            dec_data_r    <= dec_data_next_s;
            frame_valid_r <= frame_valid_next_s;
            frame_error_r <= frame_error_next_s;
            error_code_r  <= error_code_next_s;
            busy_r        <= busy_next_s;
            frames_ok_r   <= frames_ok_next_s;
            frames_bad_r  <= frames_bad_next_s;
        end
    end

    assign dec_reset   = dec_reset_r;
    assign dec_shift   = dec_shift_r;
    assign dec_data    = dec_data_r;
    assign frame_valid = frame_valid_r;
    assign frame_error = frame_error_r;
    assign error_code  = error_code_r;
    assign busy        = busy_r;
    assign frames_ok   = frames_ok_r;
    assign frames_bad  = frames_bad_r;

endmodule

// File: tb/tb_bep_frame_controller.sv
// -----------------------------------------------------------------------------
// Testbench for bep_frame_controller. A behavioural decoder (shift register with
// full flag and preamble field) sits on the decoder ports. Expected shifted bits
// and expected frame outcomes are queued as stimulus is driven and popped by a
// monitor when the DUT produces them. Frame length and gap timeout are scaled
// down so that the 256-frame saturation run stays short.
// -----------------------------------------------------------------------------
module tb_bep_frame_controller;

    localparam int          FB    = 64;
    localparam logic [19:0] GAP_T = 20'd200;
    localparam logic [31:0] PRE   = 32'hAAAAAAAA;

    typedef struct packed {
        logic       good;
        logic [1:0] code;
    } outcome_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        serial_clk_in = 1'b0;
    logic        serial_dat_in = 1'b0;
    logic        dec_reset, dec_shift, dec_data, dec_full;
    logic [31:0] dec_preamble;
    logic        frame_valid;
    logic        frame_ack = 1'b0;
    logic        frame_error;
    logic [1:0]  error_code;
    logic        busy;
    logic [7:0]  frames_ok, frames_bad;
    logic        force_full = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int shift_cnt = 0;
    int last_shift_cyc = 0;
    int err_cyc = 0;
    logic fv_prev = 1'b0;
    logic [7:0] exp_ok = 8'd0;
    logic [7:0] exp_bad = 8'd0;

    logic     bitq[$];
    outcome_t outq[$];

    bep_frame_controller #(
        .FRAME_BITS (FB),
        .PREAMBLE   (PRE),
        .GAP_TIMEOUT(GAP_T)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .serial_clk_in(serial_clk_in),
        .serial_dat_in(serial_dat_in),
        .dec_reset    (dec_reset),
        .dec_shift    (dec_shift),
        .dec_data     (dec_data),
        .dec_full     (dec_full),
        .dec_preamble (dec_preamble),
        .frame_valid  (frame_valid),
        .frame_ack    (frame_ack),
        .frame_error  (frame_error),
        .error_code   (error_code),
        .busy         (busy),
        .frames_ok    (frames_ok),
        .frames_bad   (frames_bad)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Behavioural decoder: first bit shifted in ends up at the MSB.
    logic [FB-1:0] dec_sr = '0;
    int            dec_cnt = 0;
    always @(posedge clock) begin
        if (dec_reset) begin
            dec_sr  <= '0;
            dec_cnt <= 0;
        end else if (dec_shift) begin
            dec_sr  <= {dec_sr[FB-2:0], dec_data};
            dec_cnt <= dec_cnt + 1;
        end
    end
    assign dec_full     = (dec_cnt >= FB) || force_full;
    assign dec_preamble = dec_sr[FB-1 -: 32];

    // Scoreboard consumer: shifted bits and frame outcomes.
    always @(negedge clock) begin
        logic     eb;
        outcome_t eo;
        outcome_t go;
        if (!reset) begin
            if (dec_shift) begin
                shift_cnt++;
                last_shift_cyc = cyc;
                checks++;
                if (bitq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_shift: dec_shift=1 with no bit expected (cycle %0d)", cyc);
                end else begin
                    eb = bitq.pop_front();
                    if (dec_data !== eb) begin
                        errors++;
                        $display("FAIL dec_data: got %b expected %b (cycle %0d)", dec_data, eb, cyc);
                    end
                end
            end
            if (frame_error || (frame_valid && !fv_prev)) begin
                if (frame_error) err_cyc = cyc;
                go.good = ~frame_error;
                go.code = frame_error ? error_code : 2'b00;
                checks++;
                if (outq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_outcome: got good=%b code=%b with none expected", go.good, go.code);
                end else begin
                    eo = outq.pop_front();
                    if (go !== eo) begin
                        errors++;
                        $display("FAIL outcome: got good=%b code=%b expected good=%b code=%b",
                                 go.good, go.code, eo.good, eo.code);
                    end
                end
                if (frame_error) begin
                    checks++;
                    if (dec_reset !== 1'b1) begin
                        errors++;
                        $display("FAIL err_dec_reset: got %b expected 1", dec_reset);
                    end
                end
            end
        end
        fv_prev = frame_valid;
    end

    task automatic send_bits(input logic [63:0] pat, input int n);
        for (int i = 0; i < n; i++) begin
            serial_dat_in = pat[63-i];
            serial_clk_in = 1'b0;
            bitq.push_back(pat[63-i]);
            @(negedge clock);
            serial_clk_in = 1'b1;
            @(negedge clock);
        end
        serial_clk_in = 1'b0;
    endtask

    task automatic send_edges(input int n);
        for (int i = 0; i < n; i++) begin
            serial_dat_in = 1'b1;
            serial_clk_in = 1'b0;
            @(negedge clock);
            serial_clk_in = 1'b1;
            @(negedge clock);
        end
        serial_clk_in = 1'b0;
    endtask

    task automatic wait_outcome(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (outq.size() == 0) break;
            @(negedge clock);
        end
        if (outq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL outcome_timeout: %0d outcomes pending after %0d cycles", outq.size(), budget);
            outq.delete();
        end
    endtask

    task automatic wait_bits(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (bitq.size() == 0) break;
            @(negedge clock);
        end
        if (bitq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL bits_timeout: %0d bits pending", bitq.size());
            bitq.delete();
        end
    endtask

    task automatic pulse_ack();
        frame_ack = 1'b1;
        @(negedge clock);
        frame_ack = 1'b0;
    endtask

    task automatic good_frame();
        outcome_t o;
        o.good = 1'b1;
        o.code = 2'b00;
        outq.push_back(o);
        send_bits({PRE, $urandom()}, FB);
        wait_outcome(40);
        if (exp_ok != 8'hFF) exp_ok = exp_ok + 8'd1;
    endtask

    task automatic test_reset();
        int seen;
        reset = 1'b1;
        repeat (3) @(negedge clock);
        checks++; if ({dec_reset, dec_shift, dec_data} !== 3'b000) begin errors++; $display("FAIL rst_dec: got %b expected 000", {dec_reset, dec_shift, dec_data}); end
        checks++; if ({frame_valid, frame_error, busy} !== 3'b000) begin errors++; $display("FAIL rst_status: got %b expected 000", {frame_valid, frame_error, busy}); end
        checks++; if (error_code !== 2'b00) begin errors++; $display("FAIL rst_code: got %b expected 00", error_code); end
        checks++; if ({frames_ok, frames_bad} !== 16'h0000) begin errors++; $display("FAIL rst_counts: got %h expected 0000", {frames_ok, frames_bad}); end
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            if (dec_reset === 1'b1) seen++;
        end
        checks++; if (seen != 1) begin errors++; $display("FAIL rst_clear_pulse: got %0d pulses expected 1", seen); end
        exp_ok = 8'd0;
        exp_bad = 8'd0;
    endtask

    task automatic test_good_frame();
        outcome_t o;
        int base;
        logic [63:0] pat;
        base = shift_cnt;
        pat = {PRE, 32'h1234_5678};
        o.good = 1'b1;
        o.code = 2'b00;
        outq.push_back(o);
        send_bits(pat, 32);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_mid: got %b expected 1", busy); end
        send_bits(pat << 32, 32);
        wait_outcome(40);
        exp_ok = exp_ok + 8'd1;
        checks++; if (shift_cnt - base != FB) begin errors++; $display("FAIL shift_count: got %0d expected %0d", shift_cnt - base, FB); end
        checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL good_valid: got %b expected 1", frame_valid); end
        checks++; if (frames_ok !== exp_ok) begin errors++; $display("FAIL good_ok: got %0d expected %0d", frames_ok, exp_ok); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL hold_busy: got %b expected 0", busy); end
        pulse_ack();
        checks++; if ({frame_valid, dec_reset} !== 2'b01) begin errors++; $display("FAIL ack_clear: got valid,dec_reset=%b expected 01", {frame_valid, dec_reset}); end
    endtask

    task automatic test_bad_preamble();
        outcome_t o;
        o.good = 1'b0;
        o.code = 2'b10;
        outq.push_back(o);
        send_bits({32'hAAAAAAAB, $urandom()}, FB);
        wait_outcome(40);
        exp_bad = exp_bad + 8'd1;
        checks++; if (error_code !== 2'b10) begin errors++; $display("FAIL pre_code: got %b expected 10", error_code); end
        checks++; if (frames_bad !== exp_bad) begin errors++; $display("FAIL pre_bad: got %0d expected %0d", frames_bad, exp_bad); end
        checks++; if (frames_ok !== exp_ok) begin errors++; $display("FAIL pre_ok: got %0d expected %0d", frames_ok, exp_ok); end
        checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL pre_valid: got %b expected 0", frame_valid); end
    endtask

    task automatic test_gap_timeout();
        outcome_t o;
        o.good = 1'b0;
        o.code = 2'b01;
        outq.push_back(o);
        send_bits({$urandom(), $urandom()}, 40);
        wait_outcome(int'(GAP_T) + 60);
        exp_bad = exp_bad + 8'd1;
        checks++; if (err_cyc - last_shift_cyc != int'(GAP_T)) begin errors++; $display("FAIL gap_delay: got %0d expected %0d", err_cyc - last_shift_cyc, GAP_T); end
        checks++; if (error_code !== 2'b01) begin errors++; $display("FAIL gap_code: got %b expected 01", error_code); end
        checks++; if (frames_bad !== exp_bad) begin errors++; $display("FAIL gap_bad: got %0d expected %0d", frames_bad, exp_bad); end
        repeat (3) @(negedge clock);
        checks++; if (error_code !== 2'b01) begin errors++; $display("FAIL gap_code_held: got %b expected 01", error_code); end
        good_frame();
        checks++; if (frames_ok !== exp_ok) begin errors++; $display("FAIL gap_next_ok: got %0d expected %0d", frames_ok, exp_ok); end
        pulse_ack();
    endtask

    task automatic test_length_mismatch();
        outcome_t o;
        int seen;
        o.good = 1'b0;
        o.code = 2'b11;
        outq.push_back(o);
        send_bits({PRE, $urandom()}, 50);
        wait_bits(10);
        force_full = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (frame_error === 1'b1) begin
                seen = 1;
                break;
            end
        end
        force_full = 1'b0;
        wait_outcome(5);
        exp_bad = exp_bad + 8'd1;
        checks++; if (seen != 1) begin errors++; $display("FAIL len_error_seen: got %0d expected 1", seen); end
        checks++; if (error_code !== 2'b11) begin errors++; $display("FAIL len_code: got %b expected 11", error_code); end
        checks++; if (frames_bad !== exp_bad) begin errors++; $display("FAIL len_bad: got %0d expected %0d", frames_bad, exp_bad); end
    endtask

    task automatic test_hold_edges();
        int base;
        repeat (3) @(negedge clock);
        pulse_ack();
        checks++; if (dec_reset !== 1'b0) begin errors++; $display("FAIL ack_idle: got dec_reset %b expected 0", dec_reset); end
        good_frame();
        base = shift_cnt;
        send_edges(10);
        repeat (6) @(negedge clock);
        checks++; if (shift_cnt != base) begin errors++; $display("FAIL hold_shift: got %0d shifts expected 0", shift_cnt - base); end
        checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL hold_valid: got %b expected 1", frame_valid); end
        checks++; if ({frames_ok, frames_bad} !== {exp_ok, exp_bad}) begin errors++; $display("FAIL hold_counts: got %h expected %h", {frames_ok, frames_bad}, {exp_ok, exp_bad}); end
        pulse_ack();
        checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL hold_ack: got %b expected 0", frame_valid); end
    endtask

    task automatic test_reset_mid_frame();
        int seen;
        send_bits({PRE, $urandom()}, 30);
        wait_bits(10);
        reset = 1'b1;
        @(negedge clock);
        checks++; if ({frame_valid, frame_error, busy, dec_shift, dec_reset} !== 5'b00000) begin errors++; $display("FAIL mid_rst_status: got %b expected 00000", {frame_valid, frame_error, busy, dec_shift, dec_reset}); end
        checks++; if ({frames_ok, frames_bad, error_code} !== 18'd0) begin errors++; $display("FAIL mid_rst_counts: got %h expected 0", {frames_ok, frames_bad, error_code}); end
        repeat (2) @(negedge clock);
        bitq.delete();
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            if (dec_reset === 1'b1) seen++;
        end
        checks++; if (seen != 1) begin errors++; $display("FAIL mid_rst_clear: got %0d pulses expected 1", seen); end
        exp_ok = 8'd0;
        exp_bad = 8'd0;
    endtask

    task automatic test_saturation();
        for (int f = 0; f < 256; f++) begin
            good_frame();
            if (f == 0) begin
                checks++; if (frames_ok !== 8'd1) begin errors++; $display("FAIL sat_first: got %0d expected 1", frames_ok); end
            end
            if (f == 254) begin
                checks++; if (frames_ok !== 8'hFF) begin errors++; $display("FAIL sat_255: got %0d expected 255", frames_ok); end
            end
            pulse_ack();
        end
        checks++; if (frames_ok !== 8'hFF) begin errors++; $display("FAIL sat_hold: got %0d expected 255", frames_ok); end
        checks++; if (frames_bad !== 8'd0) begin errors++; $display("FAIL sat_bad: got %0d expected 0", frames_bad); end
    endtask

    initial begin
        @(negedge clock);
        test_reset();
        test_good_frame();
        test_bad_preamble();
        test_gap_timeout();
        test_length_mismatch();
        test_hold_edges();
        test_reset_mid_frame();
        test_saturation();
        repeat (4) @(negedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
